// File: rtl/store_buffer_pkg.sv
// Shared types for the posted-store buffer: entry layout, FSM encodings and the top-level register.
// Load forwarding from queued stores is enabled by defining STORE_BUFFER_FWD_EN.
package store_buffer_pkg;

  localparam int SB_DEPTH = 4;

  typedef struct packed {
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [3:0]  wstrb;
  } store_buffer_entry_type;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    STW   = 3'd1,
    DRAIN = 3'd2,
    LOAD  = 3'd3,
    RESP  = 3'd4
  } sb_state_type;

  typedef enum logic {
    M_IDLE = 1'b0,
    M_BUSY = 1'b1
  } sb_mstate_type;

  // Whole controller state in one struct so checkers can bind to r_q directly.
  typedef struct packed {
    sb_state_type           cstate;
    sb_mstate_type          mstate;
    logic                   m_load;
    store_buffer_entry_type req;
    logic                   req_fence;
    logic [31:0]            rdata;
    logic                   dmem_valid;
    store_buffer_entry_type dmem;
  } store_buffer_reg_type;

  localparam store_buffer_reg_type init_store_buffer_reg = '{
    cstate:     IDLE,
    mstate:     M_IDLE,
    m_load:     1'b0,
    req:        '0,
    req_fence:  1'b0,
    rdata:      '0,
    dmem_valid: 1'b0,
    dmem:       '0
  };

endpackage

// File: rtl/store_buffer_fifo.sv
// In-order store queue with wrap-bit pointers; optionally searches valid entries for a word-address match.
// The match logic exists only when STORE_BUFFER_FWD_EN is defined.
module store_buffer_fifo
  import store_buffer_pkg::*;
#(
  parameter int DEPTH = SB_DEPTH
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   enq_i,
  input  store_buffer_entry_type enq_entry_i,
  input  logic                   deq_i,
  input  logic [29:0]            match_addr_i,
  output store_buffer_entry_type head_o,
  output logic                   full_o,
  output logic                   empty_o,
  output logic                   hit_o,
  output logic                   hit_full_o,
  output logic [31:0]            hit_data_o
);

  localparam int AW = $clog2(DEPTH);

  logic [AW:0]            wr_q, wr_d, rd_q, rd_d;
  store_buffer_entry_type mem_q [DEPTH];

  assign wr_d    = wr_q + (AW + 1)'(enq_i);
  assign rd_d    = rd_q + (AW + 1)'(deq_i);
  assign full_o  = (wr_q[AW] != rd_q[AW]) && (wr_q[AW-1:0] == rd_q[AW-1:0]);
  assign empty_o = (wr_q == rd_q);
  assign head_o  = mem_q[rd_q[AW-1:0]];

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_q <= '0;
      rd_q <= '0;
    end else begin
      wr_q <= wr_d;
      rd_q <= rd_d;
    end
  end

  always_ff @(posedge clk) begin
    if (enq_i) mem_q[wr_q[AW-1:0]] <= enq_entry_i;
  end

`ifdef STORE_BUFFER_FWD_EN
  logic [AW:0]   count;
  logic [AW-1:0] idx;

  // Walk oldest to youngest so the youngest matching entry wins.
  always_comb begin
    hit_o      = 1'b0;
    hit_full_o = 1'b0;
    hit_data_o = '0;
    idx        = '0;
    count      = wr_q - rd_q;
    for (int k = 0; k < DEPTH; k++) begin
      idx = rd_q[AW-1:0] + AW'(k);
      if (((AW + 1)'(k) < count) && (mem_q[idx].addr[31:2] == match_addr_i)) begin
        hit_o      = 1'b1;
        hit_full_o = (mem_q[idx].wstrb == 4'hF);
        hit_data_o = mem_q[idx].wdata;
      end
    end
  end
`else
  logic unused_match;
  assign unused_match = ^match_addr_i;
  assign hit_o        = 1'b0;
  assign hit_full_o   = 1'b0;
  assign hit_data_o   = '0;
`endif

endmodule

// File: rtl/store_buffer.sv
// Posted-store buffer: CPU-side request FSM, memory-side issue FSM and the dmem port mux.
// Defining STORE_BUFFER_FWD_EN lets loads bypass or forward from queued stores.
module store_buffer
  import store_buffer_pkg::*;
#(
  parameter int DEPTH = SB_DEPTH
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        mem_valid,
  input  logic        mem_fence,
  input  logic [31:0] mem_addr,
  input  logic [31:0] mem_wdata,
  input  logic [3:0]  mem_wstrb,
  output logic [31:0] mem_rdata,
  output logic        mem_ready,
  output logic        dmem_valid,
  output logic [31:0] dmem_addr,
  output logic [31:0] dmem_wdata,
  output logic [3:0]  dmem_wstrb,
  input  logic [31:0] dmem_rdata,
  input  logic        dmem_ready,
  output logic        sb_empty
);

  store_buffer_reg_type   r_q, r_d;
  store_buffer_entry_type enq_entry, head;
  logic                   enq, deq, fifo_full, fifo_empty, full_eff;
  logic                   store_done, load_done;
  logic                   fwd_hit, fwd_full;
  logic [31:0]            fwd_data;

  store_buffer_fifo #(.DEPTH(DEPTH)) u_fifo (
    .clk          (clk),
    .rst          (rst),
    .enq_i        (enq),
    .enq_entry_i  (enq_entry),
    .deq_i        (deq),
    .match_addr_i (mem_addr[31:2]),
    .head_o       (head),
    .full_o       (fifo_full),
    .empty_o      (fifo_empty),
    .hit_o        (fwd_hit),
    .hit_full_o   (fwd_full),
    .hit_data_o   (fwd_data)
  );

`ifndef STORE_BUFFER_FWD_EN
  logic unused_fwd;
  assign unused_fwd = ^{fwd_hit, fwd_full, fwd_data};
`endif

  always_comb begin
    r_d        = r_q;
    r_d.dmem_valid = 1'b0;
    enq        = 1'b0;
    enq_entry  = r_q.req;
    store_done = (r_q.mstate == M_BUSY) && dmem_ready && !r_q.m_load;
    load_done  = (r_q.mstate == M_BUSY) && dmem_ready && r_q.m_load;
    deq        = store_done;
    // A retiring entry frees its slot in the same cycle a waiting store claims it.
    full_eff   = fifo_full && !store_done;

    case (r_q.cstate)
      IDLE: begin
        if (mem_valid) begin
          r_d.req       = '{addr: mem_addr, wdata: mem_wdata, wstrb: mem_wstrb};
          r_d.req_fence = mem_fence;
          if (mem_fence) begin
            r_d.cstate = DRAIN;
          end else if (mem_wstrb != 4'h0) begin
            if (!full_eff) begin
              enq        = 1'b1;
              enq_entry  = '{addr: mem_addr, wdata: mem_wdata, wstrb: mem_wstrb};
              r_d.cstate = RESP;
            end else begin
              r_d.cstate = STW;
            end
          end else begin
`ifdef STORE_BUFFER_FWD_EN
            if (!fwd_hit) begin
              r_d.cstate = LOAD;
            end else if (fwd_full) begin
              r_d.rdata  = fwd_data;
              r_d.cstate = RESP;
            end else begin
              r_d.cstate = DRAIN;
            end
`else
            r_d.cstate = DRAIN;
`endif
          end
        end
      end
      STW: begin
        if (!full_eff) begin
          enq        = 1'b1;
          r_d.cstate = RESP;
        end
      end
      DRAIN: begin
        if (fifo_empty) r_d.cstate = r_q.req_fence ? RESP : LOAD;
      end
      LOAD: begin
        if (load_done) begin
          r_d.rdata  = dmem_rdata;
          r_d.cstate = RESP;
        end
      end
      RESP:    r_d.cstate = IDLE;
      default: r_d.cstate = IDLE;
    endcase

    // A load in LOAD has priority for the port; stores resume once it completes.
    case (r_q.mstate)
      M_IDLE: begin
        if (r_q.cstate == LOAD) begin
          r_d.dmem_valid = 1'b1;
          r_d.dmem       = '{addr: r_q.req.addr, wdata: 32'h0, wstrb: 4'h0};
          r_d.m_load     = 1'b1;
          r_d.mstate     = M_BUSY;
        end else if (!fifo_empty) begin
          r_d.dmem_valid = 1'b1;
          r_d.dmem       = head;
          r_d.m_load     = 1'b0;
          r_d.mstate     = M_BUSY;
        end
      end
      M_BUSY: begin
        if (dmem_ready) r_d.mstate = M_IDLE;
      end
      default: r_d.mstate = M_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) r_q <= init_store_buffer_reg;
    else      r_q <= r_d;
  end

  assign mem_ready  = (r_q.cstate == RESP);
  assign mem_rdata  = r_q.rdata;
  assign dmem_valid = r_q.dmem_valid;
  assign dmem_addr  = r_q.dmem.addr;
  assign dmem_wdata = r_q.dmem.wdata;
  assign dmem_wstrb = r_q.dmem.wstrb;
  assign sb_empty   = fifo_empty;

endmodule
